fram_rd_ctrl: RTL and testbench

Read-side controller for the on-chip frame buffer: generates 640×480 display timing, drives the buffer's read enable and read-counter clear, and re-times the returned 10-bit raw pixel stream into aligned sync/DE/data outputs for the display path. It sits between the frame buffer's read port and the VGA/HDMI output stage, in the read clock domain. Frame hand-off from the write side is a one-cycle ready pulse, already synchronised to this clock.

---
 rtl/fram_rd_pkg.sv | 35 +++
 rtl/fram_rd_if.sv | 25 ++
 rtl/fram_rd_delay.sv | 26 ++
 rtl/fram_rd_ctrl.sv | 130 +++++++++++++
 tb/tb_fram_rd_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/fram_rd_pkg.sv
// Shared constants, timing helpers and the delayed timing payload for fram_rd_ctrl.
package fram_rd_pkg;

    localparam int unsigned H_ACT_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_ACT_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;
    localparam int unsigned RD_LAT_DEF = 2;
    localparam int unsigned PIX_W      = 10;

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned total);
        return $clog2(total);
    endfunction

    // tp_de/pat only carry information in the test-pattern build
    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic             tp_de;
        logic [PIX_W-1:0] pat;
    } tim_t;

    localparam tim_t TIM_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, tp_de: 1'b0, pat: '0};

endpackage

// File: rtl/fram_rd_if.sv
// Frame-buffer read port plus display-side outputs of the read controller.
interface fram_rd_if;
    import fram_rd_pkg::*;

    logic             FRM_READY;
    logic [PIX_W-1:0] R_DATA;
    logic             RD_DE;
    logic             RD_CLR;
    logic             VGA_HS;
    logic             VGA_VS;
    logic             VGA_DE;
    logic [PIX_W-1:0] VGA_DATA;
    logic             FRM_REPEAT;

    modport master (
        input  FRM_READY, R_DATA,
        output RD_DE, RD_CLR, VGA_HS, VGA_VS, VGA_DE, VGA_DATA, FRM_REPEAT
    );

    modport slave (
        output FRM_READY, R_DATA,
        input  RD_DE, RD_CLR, VGA_HS, VGA_VS, VGA_DE, VGA_DATA, FRM_REPEAT
    );

endinterface

// File: rtl/fram_rd_delay.sv
// Fixed-depth shift register for the timing payload; CLR loads the inactive values.
module fram_rd_delay
    import fram_rd_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  tim_t d_i,
    output tim_t q_o
);

    tim_t sr_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= TIM_IDLE;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fram_rd_ctrl.sv
// Frame-buffer read controller: display timing, buffer read enable/clear, aligned sync/DE/data.
// Build option FRAM_RD_TESTPAT_EN: shows an h+v pattern while no valid frame is available.
module fram_rd_ctrl
    import fram_rd_pkg::*;
#(
    parameter int unsigned H_ACT  = H_ACT_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_ACT  = V_ACT_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic      CLOCK,
    input  logic      CLR,
    fram_rd_if.master bus
);

    localparam int unsigned H_TOT = line_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOT = line_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW    = cnt_w(H_TOT);
    localparam int unsigned VW    = cnt_w(V_TOT);

    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic             rdy_q, rdy_d;
    logic             valid_q, valid_d;
    logic             rpt_q, rpt_d;
    logic             rd_de_q, rd_de_d;
    logic             rd_clr_q, rd_clr_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             h_wrap_c, bnd_c, act_c, ready_c;
    tim_t             tim_c, tap_c;

    // Counters, frame hand-off and buffer control; RD_DE/RD_CLR are decoded from the next counts
    always_comb begin
        h_d      = h_q + HW'(1);
        v_d      = v_q;
        rdy_d    = rdy_q | bus.FRM_READY;
        valid_d  = valid_q;
        rpt_d    = rpt_q;
        ready_c  = rdy_q | bus.FRM_READY;
        h_wrap_c = (h_q == HW'(H_TOT - 1));
        bnd_c    = h_wrap_c && (v_q == VW'(V_TOT - 1));
        if (h_wrap_c) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + VW'(1);
        end
        if (bnd_c) begin
            rdy_d   = 1'b0;
            valid_d = valid_q | ready_c;
            rpt_d   = valid_q & ~ready_c;
        end
        rd_de_d  = (h_d < HW'(H_ACT)) && (v_d < VW'(V_ACT)) && valid_d;
        rd_clr_d = (h_d == HW'(H_TOT - 1)) && (v_d == VW'(V_TOT - 1));
    end

    // Raw timing for the current counter position
    always_comb begin
        act_c    = (h_q < HW'(H_ACT)) && (v_q < VW'(V_ACT));
        tim_c    = TIM_IDLE;
        tim_c.hs = !((h_q >= HW'(H_ACT + H_FP)) && (h_q < HW'(H_ACT + H_FP + H_SYNC)));
        tim_c.vs = !((v_q >= VW'(V_ACT + V_FP)) && (v_q < VW'(V_ACT + V_FP + V_SYNC)));
        tim_c.de = act_c & valid_q;
`ifdef FRAM_RD_TESTPAT_EN
        tim_c.tp_de = act_c & ~valid_q;
        tim_c.pat   = PIX_W'(h_q) + PIX_W'(v_q);
`else
        tim_c.tp_de = 1'b0;
        tim_c.pat   = '0;
`endif
    end

    // RD_LAT stages here plus the output register give RD_LAT+1 cycles of alignment
    fram_rd_delay #(.DEPTH(RD_LAT)) u_delay (
        .clk_i (CLOCK),
        .clr_i (CLR),
        .d_i   (tim_c),
        .q_o   (tap_c)
    );

    always_comb begin
        hs_d   = tap_c.hs;
        vs_d   = tap_c.vs;
        de_d   = tap_c.de | tap_c.tp_de;
        data_d = '0;
        if (tap_c.de)         data_d = bus.R_DATA;
        else if (tap_c.tp_de) data_d = tap_c.pat;
    end

    always_ff @(posedge CLOCK) begin
        if (CLR) begin
            h_q      <= '0;
            v_q      <= '0;
            rdy_q    <= 1'b0;
            valid_q  <= 1'b0;
            rpt_q    <= 1'b0;
            rd_de_q  <= 1'b0;
            rd_clr_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            rdy_q    <= rdy_d;
            valid_q  <= valid_d;
            rpt_q    <= rpt_d;
            rd_de_q  <= rd_de_d;
            rd_clr_q <= rd_clr_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            data_q   <= data_d;
        end
    end

    assign bus.RD_DE      = rd_de_q;
    assign bus.RD_CLR     = rd_clr_q;
    assign bus.VGA_HS     = hs_q;
    assign bus.VGA_VS     = vs_q;
    assign bus.VGA_DE     = de_q;
    assign bus.VGA_DATA   = data_q;
    assign bus.FRM_REPEAT = rpt_q;

endmodule

// File: tb/tb_fram_rd_ctrl.sv
// Directed bench for fram_rd_ctrl on a reduced 16x10 raster (8x6 active, RD_LAT = 2).
module tb_fram_rd_ctrl;

    localparam int T_END = 1340;

    typedef struct {
        int          t;
        string       name;
        logic [15:0] exp;   // {RD_DE, RD_CLR, HS, VS, DE, DATA[9:0], REPEAT}
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    fram_rd_if bus ();

    fram_rd_ctrl #(
        .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .RD_LAT(2)
    ) dut (
        .CLOCK (clk),
        .CLR   (clr),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic vec_t mk(input int t, input string n, input logic rd, input logic cl,
                                input logic hs, input logic vs, input logic de,
                                input logic [9:0] d, input logic rp);
        vec_t v;
        v.t    = t;
        v.name = n;
        v.exp  = {rd, cl, hs, vs, de, d, rp};
        return v;
    endfunction

    // Buffer model: word address counts RD_DE cycles since RD_CLR, returned 2 cycles later
    logic [9:0] m_addr = '0, m_p0 = 10'h3FF, m_p1 = 10'h3FF;
    initial begin
        bus.R_DATA = 10'h3FF;
        forever begin
            @(negedge clk);
            bus.R_DATA = m_p1;
            m_p1 = m_p0;
            m_p0 = bus.RD_DE ? m_addr : 10'h3FF;
            if (bus.RD_CLR)     m_addr = '0;
            else if (bus.RD_DE) m_addr = m_addr + 10'd1;
        end
    end

    vec_t        vecs[$];
    int          vi;
    logic [15:0] obs;
    int          c_rd, c_clr, c_hs, c_vs, c_de, c_dat;
    int          s_o, s_r, ho, vo;
    logic        e_act;
    logic [13:0] e_sw;

    initial begin
        vecs.push_back(mk(   0, "reset",         0, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk(  13, "hs_low",        0, 0, 0, 1, 0, 10'd0, 0));
        vecs.push_back(mk(  16, "hs_release",    0, 0, 1, 1, 0, 10'd0, 0));
`ifdef FRAM_RD_TESTPAT_EN
        vecs.push_back(mk(  56, "pix_5_3",       0, 0, 1, 1, 1, 10'd8, 0));
`else
        vecs.push_back(mk(  56, "pix_5_3",       0, 0, 1, 1, 0, 10'd0, 0));
`endif
        vecs.push_back(mk( 115, "vs_low",        0, 0, 1, 0, 0, 10'd0, 0));
        vecs.push_back(mk( 147, "vs_release",    0, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 159, "rd_clr_f0",     0, 1, 0, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 478, "pre_bnd",       0, 0, 0, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 479, "rd_clr_pulse",  0, 1, 0, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 480, "first_rd_de",   1, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 483, "first_pixel",   1, 0, 1, 1, 1, 10'd0, 0));
        vecs.push_back(mk( 490, "line0_last",    0, 0, 1, 1, 1, 10'd7, 0));
        vecs.push_back(mk( 499, "line1_first",   1, 0, 1, 1, 1, 10'd8, 0));
        vecs.push_back(mk( 640, "repeat_set",    1, 0, 1, 1, 0, 10'd0, 1));
        vecs.push_back(mk( 799, "bnd_ready",     0, 1, 0, 1, 0, 10'd0, 1));
        vecs.push_back(mk( 800, "repeat_clear",  1, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk( 853, "clr_reset",     0, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk(1173, "rd_de_resume",  1, 0, 1, 1, 0, 10'd0, 0));
        vecs.push_back(mk(1176, "resume_pixel0", 1, 0, 1, 1, 1, 10'd0, 0));

        clr = 1'b1;
        bus.FRM_READY = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        vi = 0;
        c_rd = 0; c_clr = 0; c_hs = 0; c_vs = 0; c_de = 0; c_dat = 0;

        // t is the counter position after reset; inputs set here are sampled at the end of t
        for (int t = 0; t < T_END; t++) begin
            bus.FRM_READY = (t == 357) || (t == 400) || (t == 799) || (t == 1100);
            clr = (t == 852);
            obs = {bus.RD_DE, bus.RD_CLR, bus.VGA_HS, bus.VGA_VS, bus.VGA_DE,
                   bus.VGA_DATA, bus.FRM_REPEAT};

            if (vi < vecs.size() && vecs[vi].t == t) begin
                check(vecs[vi].name, int'(obs), int'(vecs[vi].exp));
                vi++;
            end

            if (t == 0 || t == 320 || t == 480 || t == 853 || t == 1173) begin
                c_rd = 0; c_clr = 0; c_hs = 0; c_vs = 0; c_de = 0; c_dat = 0;
            end
            c_rd  += int'(bus.RD_DE);
            c_clr += int'(bus.RD_CLR);
            c_hs  += int'(!bus.VGA_HS);
            c_vs  += int'(!bus.VGA_VS);
            c_de  += int'(bus.VGA_DE);
            c_dat += int'(bus.VGA_DATA != 10'd0);

            if (t == 319) begin
                check("idle_rd_de_cnt", c_rd, 0);
                check("idle_rd_clr_cnt", c_clr, 2);
                check("idle_hs_low_cnt", c_hs, 60);
                check("idle_vs_low_cnt", c_vs, 64);
`ifdef FRAM_RD_TESTPAT_EN
                check("idle_tp_de_cnt", c_de, 96);
`else
                check("idle_vga_de_cnt", c_de, 0);
                check("idle_data_nonzero_cnt", c_dat, 0);
`endif
            end
            if (t == 479) check("ready_frame_rd_clr_cnt", c_clr, 1);
            if (t == 639) check("valid_frame_rd_de_cnt", c_rd, 48);
            if (t == 1172) check("after_clr_rd_de_cnt", c_rd, 0);
            if (t == 1332) check("resumed_rd_de_cnt", c_rd, 48);

            // Two valid frames: every cycle against the raster position 3 cycles back
            if (t >= 480 && t < 800) begin
                s_o   = (t - 483 + 160) % 160;
                ho    = s_o % 16;
                vo    = s_o / 16;
                s_r   = (t - 480) % 160;
                e_act = (ho < 8) && (vo < 6);
                e_sw  = {(s_r % 16 < 8) && (s_r / 16 < 6),
                         !(ho >= 10 && ho < 13), !(vo >= 7 && vo < 9),
                         e_act, e_act ? 10'(vo * 8 + ho) : 10'd0};
                check($sformatf("sweep_t%0d", t),
                      int'({bus.RD_DE, bus.VGA_HS, bus.VGA_VS, bus.VGA_DE, bus.VGA_DATA}),
                      int'(e_sw));
            end

            @(negedge clk);
        end

        check("vectors_applied", vi, vecs.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
